// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared game-wide constants and enumerations used by the enemy AI.
//   POS_WIDTH   : width of every on-screen x coordinate
//   ai_state_e  : enemy AI controller states
//   ai_action_e : action chosen by the enemy AI on a decision cycle
// The action names carry an A_ prefix so that A_DEFEND does not collide with
// the DEFEND state in the same package scope.
// ---------------------------------------------------------------------------
package game_pkg;

   localparam int POS_WIDTH = 10;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      DECIDE,
      ACT,
      DEFEND
   } ai_state_e;

   typedef enum logic [2:0] {
      A_NONE,
      A_LEFT,
      A_RIGHT,
      A_JUMP,
      A_SQUAT,
      A_ATTACK,
      A_DEFEND
   } ai_action_e;

endpackage

// File: rtl/ai_lfsr16.sv
// ---------------------------------------------------------------------------
// ai_lfsr16
// 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every clk and is
// returned to SEED only by reset. With a non-zero seed it never reaches 0.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous, active-low reset (loads SEED)
//   q     : current 16-bit LFSR state
// ---------------------------------------------------------------------------
module ai_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   logic feedback;

   // Tap positions 16,14,13,11 map to bits 15,13,12,10.
   assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED;
      end else begin
         q <= {q[14:0], feedback};
      end
   end

endmodule

// File: rtl/enemy_ai.sv
// ---------------------------------------------------------------------------
// enemy_ai
// Autonomous controller standing in for a second human player. Once per
// frame tick it samples the player, enemy and bullet positions, picks an
// action and drives the six enemy action lines.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_enable          : high only while the game is in PLAY
//   i_tick            : one-clk frame strobe
//   i_player_x        : player x coordinate
//   i_enemy_x         : enemy x coordinate
//   i_bullet_x        : player bullet x coordinate
//   i_bullet_active   : player bullet alive
//   o_right, o_left, o_squat, o_defend : level outputs held for the action window
//   o_jump, o_attack  : single-clk pulses
//
// Build option:
//   ENEMY_AI_RANDOM_EN : when defined, an ai_lfsr16 gates the attack rule and
//                        picks a random filler action; when undefined the
//                        controller is fully deterministic (attack whenever the
//                        cooldown allows, otherwise stay idle).
// ---------------------------------------------------------------------------
module enemy_ai #(
   parameter int          POS_WIDTH       = game_pkg::POS_WIDTH,
   parameter int          DECIDE_TICKS    = 8,
   parameter int          DEFEND_TICKS    = 16,
   parameter int          ATTACK_CD_TICKS = 32,
   parameter int          NEAR_DIST       = 64,
   parameter int          THREAT_DIST     = 48,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_enable,
   input  logic                 i_tick,
   input  logic [POS_WIDTH-1:0] i_player_x,
   input  logic [POS_WIDTH-1:0] i_enemy_x,
   input  logic [POS_WIDTH-1:0] i_bullet_x,
   input  logic                 i_bullet_active,
   output logic                 o_right,
   output logic                 o_left,
   output logic                 o_jump,
   output logic                 o_squat,
   output logic                 o_attack,
   output logic                 o_defend
);

   import game_pkg::*;

   localparam int DW    = POS_WIDTH + 1;
   localparam int CNT_W = 16;

   localparam logic [DW-1:0]    THREAT_D = DW'(THREAT_DIST);
   localparam logic [DW-1:0]    NEAR_D   = DW'(NEAR_DIST);
   localparam logic [CNT_W-1:0] DEC_T    = CNT_W'(DECIDE_TICKS);
   localparam logic [CNT_W-1:0] DEF_T    = CNT_W'(DEFEND_TICKS);
   localparam logic [CNT_W-1:0] ATK_T    = CNT_W'(ATTACK_CD_TICKS);

   // Signed difference one bit wider than the coordinates, then magnitude.
   // No screen-edge wrap is applied.
   function automatic logic [DW-1:0] abs_diff(input logic [POS_WIDTH-1:0] a,
                                              input logic [POS_WIDTH-1:0] b);
      logic signed [DW-1:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      abs_diff = d[DW-1] ? $unsigned(-d) : $unsigned(d);
   endfunction

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
      dec_sat = (c == '0) ? c : c - 1'b1;
   endfunction

   ai_state_e          state;
   ai_action_e         next_action;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   def_cd;
   logic [CNT_W-1:0]   atk_cd;
   logic [DW-1:0]      bullet_dist;
   logic [DW-1:0]      player_dist;
   logic               threat;
   logic               far;
   logic               rand_attack;
   logic [2:0]         rand_sel;

`ifdef ENEMY_AI_RANDOM_EN
   logic [15:0] lfsr;
   logic        unused_lfsr;

   ai_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:5];
   assign rand_attack = (lfsr[1:0] != 2'b00);
   assign rand_sel    = lfsr[4:2];
`else
   // Deterministic build: attack gated by cooldown only, filler is idle.
   assign rand_attack = 1'b1;
   assign rand_sel    = 3'd4;
`endif

   // Decision stage: evaluated combinationally, consumed only in DECIDE.
   assign bullet_dist = abs_diff(i_bullet_x, i_enemy_x);
   assign player_dist = abs_diff(i_player_x, i_enemy_x);
   assign threat      = i_bullet_active && (bullet_dist < THREAT_D);
   assign far         = (player_dist >= NEAR_D);

   always_comb begin
      next_action = A_NONE;
      if (threat) begin
         next_action = (def_cd == '0) ? A_DEFEND : A_JUMP;
      end else if (far) begin
         next_action = (i_player_x > i_enemy_x) ? A_RIGHT : A_LEFT;
      end else if ((atk_cd == '0) && rand_attack) begin
         next_action = A_ATTACK;
      end else begin
         case (rand_sel)
            3'd0:    next_action = A_JUMP;
            3'd1:    next_action = A_SQUAT;
            3'd2:    next_action = A_LEFT;
            3'd3:    next_action = A_RIGHT;
            default: next_action = A_NONE;
         endcase
      end
   end

   // Control stage: state, counters and registered action lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         def_cd   <= '0;
         atk_cd   <= '0;
         o_right  <= 1'b0;
         o_left   <= 1'b0;
         o_jump   <= 1'b0;
         o_squat  <= 1'b0;
         o_attack <= 1'b0;
         o_defend <= 1'b0;
      end else if (!i_enable) begin
         // Leaving PLAY aborts whatever is in progress, including DEFEND.
         state    <= IDLE;
         hold_cnt <= '0;
         def_cd   <= '0;
         atk_cd   <= '0;
         o_right  <= 1'b0;
         o_left   <= 1'b0;
         o_jump   <= 1'b0;
         o_squat  <= 1'b0;
         o_attack <= 1'b0;
         o_defend <= 1'b0;
      end else begin
         o_jump   <= 1'b0;
         o_attack <= 1'b0;

         // Cooldowns run on frame ticks; a reload below overrides this.
         if (i_tick && (state != IDLE)) begin
            def_cd <= dec_sat(def_cd);
            atk_cd <= dec_sat(atk_cd);
         end

         case (state)
            IDLE: begin
               state <= WAIT;
            end

            WAIT: begin
               if (i_tick) begin
                  state <= DECIDE;
               end
            end

            DECIDE: begin
               // A tick seen here is deliberately not applied to hold_cnt.
               state    <= ACT;
               hold_cnt <= DEC_T;
               case (next_action)
                  A_DEFEND: begin
                     state    <= DEFEND;
                     hold_cnt <= DEF_T;
                     o_defend <= 1'b1;
                  end
                  A_JUMP:   o_jump  <= 1'b1;
                  A_SQUAT:  o_squat <= 1'b1;
                  A_LEFT:   o_left  <= 1'b1;
                  A_RIGHT:  o_right <= 1'b1;
                  A_ATTACK: begin
                     o_attack <= 1'b1;
                     atk_cd   <= ATK_T;
                  end
                  default: ;
               endcase
            end

            ACT: begin
               if (i_tick) begin
                  if (hold_cnt <= 16'd1) begin
                     // The expiring tick is consumed here, not by WAIT.
                     hold_cnt <= '0;
                     state    <= WAIT;
                     o_right  <= 1'b0;
                     o_left   <= 1'b0;
                     o_squat  <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
            end

            DEFEND: begin
               if (i_tick) begin
                  if (hold_cnt <= 16'd1) begin
                     hold_cnt <= '0;
                     state    <= WAIT;
                     o_defend <= 1'b0;
                     // Blocks an immediate second DEFEND on the next threat.
                     def_cd   <= DEF_T;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_ai.sv
// ---------------------------------------------------------------------------
// tb_enemy_ai
// Scoreboard bench for enemy_ai. Stimulus pushes each expected change of the
// output vector {right,left,jump,squat,attack,defend}, tagged with the frame
// tick index and the number of clk edges since that tick; a monitor pops and
// compares on every observed change of the outputs.
// ---------------------------------------------------------------------------
module tb_enemy_ai;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       i_enable = 1'b0;
   logic       i_tick = 1'b0;
   logic [9:0] i_player_x = '0;
   logic [9:0] i_enemy_x = '0;
   logic [9:0] i_bullet_x = '0;
   logic       i_bullet_active = 1'b0;
   logic       o_right, o_left, o_jump, o_squat, o_attack, o_defend;

   enemy_ai dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_enable        (i_enable),
      .i_tick          (i_tick),
      .i_player_x      (i_player_x),
      .i_enemy_x       (i_enemy_x),
      .i_bullet_x      (i_bullet_x),
      .i_bullet_active (i_bullet_active),
      .o_right         (o_right),
      .o_left          (o_left),
      .o_jump          (o_jump),
      .o_squat         (o_squat),
      .o_attack        (o_attack),
      .o_defend        (o_defend)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] outs;
      int         tick;
      int         dly;
      bit         timed;
   } exp_t;

   localparam logic [5:0] M_0 = 6'b000000;
   localparam logic [5:0] M_R = 6'b100000;
   localparam logic [5:0] M_L = 6'b010000;
   localparam logic [5:0] M_J = 6'b001000;
   localparam logic [5:0] M_A = 6'b000010;
   localparam logic [5:0] M_D = 6'b000001;

   exp_t       q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         failures = 0;
   int         tick_no = 0;
   int         since = 0;
   bit         sb_en = 1'b1;
   logic [5:0] outs;
   logic [5:0] prev_outs = '0;
   int         bad_lr = 0, bad_js = 0, bad_jw = 0, bad_lfsr = 0;
   logic       prev_jump = 1'b0;

   assign outs = {o_right, o_left, o_jump, o_squat, o_attack, o_defend};

   always @(posedge clk) begin
      if (i_tick) begin
         tick_no <= tick_no + 1;
         since   <= 0;
      end else begin
         since <= since + 1;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && sb_en && (outs !== prev_outs)) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change got outs=%b tick=%0d dly=%0d required no change",
                     outs, tick_no, since);
         end else begin
            mon_e = q.pop_front();
            if ((mon_e.outs !== outs) ||
                (mon_e.timed && ((mon_e.tick != tick_no) || (mon_e.dly != since)))) begin
               failures++;
               $display("FAIL seq_event got outs=%b tick=%0d dly=%0d required outs=%b tick=%0d dly=%0d",
                        outs, tick_no, since, mon_e.outs, mon_e.tick, mon_e.dly);
            end
         end
      end
      prev_outs = outs;
   end

   // Invariant watcher for the randomised build.
   always @(negedge clk) begin
      if (!sb_en) begin
         if (o_left && o_right) bad_lr++;
         if (o_jump && o_squat) bad_js++;
         if (o_jump && prev_jump) bad_jw++;
`ifdef ENEMY_AI_RANDOM_EN
         if (dut.u_lfsr.q == 16'h0000) bad_lfsr++;
`endif
      end
      prev_jump = o_jump;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit expired pending=%0d", q.size());
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      i_tick = 1'b1;
      step(1);
      i_tick = 1'b0;
      step(3);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input logic [5:0] o, input int t, input int d, input bit tm);
      exp_t e;
      e.outs  = o;
      e.tick  = t;
      e.dly   = d;
      e.timed = tm;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b required=%b", name, got, want);
      end
   endtask

   task automatic chk_zero(input string name, input int got);
      checks++;
      if (got != 0) begin
         failures++;
         $display("FAIL %s got=%0d required=0", name, got);
      end
   endtask

   task automatic restart();
      i_enable = 1'b0;
      step(2);
      i_enable = 1'b1;
      step(2);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q.size() != 0) && (n < 50)) begin
         step(1);
         n++;
      end
      step(2);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got pending=%0d required=0", name, q.size());
         q.delete();
      end
   endtask

   initial begin
      int b;
      #1 rst_n = 1'b0;
      step(3);
      chk("reset_outs", outs, M_0);
      rst_n = 1'b1;
      step(3);
      chk("idle_disabled_outs", outs, M_0);

      // Far chase to the right, held 8 ticks.
      i_player_x = 10'd400;
      i_enemy_x  = 10'd100;
      restart();
      b = tick_no;
      push(M_R, b + 1, 1, 1'b1);
      push(M_0, b + 9, 0, 1'b1);
      ticks(5);
      chk("right_held", outs, M_R);
      ticks(4);
      drain("chase_right");

      // Far chase to the left; a second tick inside DECIDE does not shorten ACT.
      i_player_x = 10'd100;
      i_enemy_x  = 10'd400;
      restart();
      b = tick_no;
      push(M_L, b + 2, 0, 1'b1);
      push(M_0, b + 10, 0, 1'b1);
      i_tick = 1'b1;
      step(2);
      i_tick = 1'b0;
      step(2);
      ticks(8);
      drain("chase_left_decide_tick");

      // Bullet threat at close range: defend 16 ticks, then jump pulse.
      i_player_x      = 10'd100;
      i_enemy_x       = 10'd100;
      i_bullet_x      = 10'd120;
      i_bullet_active = 1'b1;
      restart();
      b = tick_no;
      push(M_D, b + 1, 1, 1'b1);
      push(M_0, b + 17, 0, 1'b1);
      push(M_J, b + 18, 1, 1'b1);
      push(M_0, b + 18, 2, 1'b1);
      ticks(26);
      drain("defend_then_jump");
      i_bullet_active = 1'b0;

`ifndef ENEMY_AI_RANDOM_EN
      // Close range, no threat: attack at decisions 1, 37, 73 only.
      i_player_x = 10'd200;
      i_enemy_x  = 10'd200;
      restart();
      b = tick_no;
      for (int k = 1; k <= 73; k += 36) begin
         push(M_A, b + k, 1, 1'b1);
         push(M_0, b + k, 2, 1'b1);
      end
      ticks(80);
      drain("attack_cooldown");
`endif

      // Enable drop mid-DEFEND, then re-enable waits for a tick.
      i_player_x      = 10'd100;
      i_enemy_x       = 10'd100;
      i_bullet_x      = 10'd80;
      i_bullet_active = 1'b1;
      restart();
      b = tick_no;
      push(M_D, b + 1, 1, 1'b1);
      ticks(5);
      chk("defend_mid", outs, M_D);
      push(M_0, 0, 0, 1'b0);
      i_enable = 1'b0;
      step(1);
      chk("disable_clears_defend", outs, M_0);
      i_enable = 1'b1;
      step(12);
      chk("reenable_waits_tick", outs, M_0);
      b = tick_no;
      push(M_D, b + 1, 1, 1'b1);
      tick();
      chk("cooldown_cleared_redefend", outs, M_D);
      push(M_0, 0, 0, 1'b0);
      i_enable = 1'b0;
      step(2);
      drain("disable_defend");
      i_bullet_active = 1'b0;

`ifdef ENEMY_AI_RANDOM_EN
      // Randomised close-range run (about 1000 decisions): invariants only.
      sb_en      = 1'b0;
      i_player_x = 10'd300;
      i_enemy_x  = 10'd300;
      restart();
      ticks(9000);
      i_enable = 1'b0;
      step(2);
      chk_zero("left_and_right", bad_lr);
      chk_zero("jump_and_squat", bad_js);
      chk_zero("jump_wider_than_1clk", bad_jw);
      chk_zero("lfsr_zero", bad_lfsr);
      sb_en = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enemy_ai.md
# enemy_ai

- Autonomous controller for the enemy character.
- Samples the current game positions once per frame tick and decides an action.
- Drives the six enemy action lines (right/left/jump/squat/attack/defend), which feed the enemy character model and the enemy bullet model in the game-control block.
- Sits directly upstream of those blocks, in the place of a second human player.

## Interface
Parameters:
- POS_WIDTH, 10, coordinate width (matches game_pkg)
- DECIDE_TICKS, 8, frame ticks an action is held
- DEFEND_TICKS, 16, frame ticks defend is held
- ATTACK_CD_TICKS, 32, minimum frame ticks between attack pulses
- NEAR_DIST, 64, horizontal distance below which the enemy stops chasing
- THREAT_DIST, 48, bullet–enemy horizontal distance treated as a threat
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  high only while the game is in PLAY
- i_tick  in  1  one-clk frame strobe
- i_player_x  in  POS_WIDTH  player x
- i_enemy_x  in  POS_WIDTH  enemy x
- i_bullet_x  in  POS_WIDTH  player bullet x
- i_bullet_active  in  1  player bullet alive
- o_right, o_left, o_squat, o_defend  out  1  level outputs, held for the action window
- o_jump, o_attack  out  1  single-clk pulses

Reset: rst_n is asynchronous, active-low; clock is clk.

## Operation
States (ai_state_e):
- IDLE
  - Entered on reset or when i_enable=0.
  - All outputs are 0 and both tick counters are cleared.
  - i_enable=1 moves to WAIT.
- WAIT
  - Outputs are 0.
  - Stays here until i_tick, then goes to DECIDE.
- DECIDE
  - Lasts one clk. Evaluates the rules below in priority order, registers the chosen outputs, then goes to ACT or DEFEND.
  - Rule 1: i_bullet_active and |i_bullet_x−i_enemy_x| < THREAT_DIST.
    - Defend cooldown is 0: go to DEFEND, assert o_defend, load DEFEND_TICKS.
    - Otherwise: pulse o_jump and go to ACT.
  - Rule 2: |i_player_x−i_enemy_x| ≥ NEAR_DIST.
    - o_right=1 if player_x > enemy_x, else o_left=1. Go to ACT.
  - Rule 3: attack cooldown is 0 and the random condition holds.
    - Pulse o_attack, load ATTACK_CD_TICKS, go to ACT.
  - Rule 4: lfsr[4:2] selects the action, then go to ACT.
    - 0 = jump pulse
    - 1 = squat
    - 2 = left
    - 3 = right
    - 4–7 = idle
- ACT
  - Holds the level outputs and loads DECIDE_TICKS.
  - Each i_tick decrements the counter; when it reaches 0, all outputs clear and the state goes to WAIT.
- DEFEND
  - Holds o_defend for DEFEND_TICKS ticks, then goes to WAIT.
  - Defend cooldown is loaded with DEFEND_TICKS on exit, so DEFEND cannot be taken twice back-to-back.

Arithmetic and counters:
- Distances are computed as a POS_WIDTH+1-bit signed difference, then the absolute value; there is no wrap at the screen edges.
- Cooldown counters decrement on i_tick in every non-IDLE state and saturate at 0.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Advances every clk, independent of i_enable.
- Returns to LFSR_SEED only on reset.

Exclusivity: o_left and o_right are never both 1. o_squat and o_jump are never both 1 in the same cycle.

## Timing
- Reset: every output is 0, state is IDLE, counters are 0, LFSR = LFSR_SEED.
- i_tick at cycle n while in WAIT: DECIDE at n+1, outputs valid at n+2.
- Pulses (o_jump, o_attack) are high for exactly one clk.
- i_enable falling:
  - All outputs are 0 on the next clk edge, from any state, including mid-DEFEND.
  - Cooldowns clear.
- i_tick arriving while in DECIDE is ignored; it does not shorten ACT.
- Simultaneous tick and counter reaching 0 in ACT: exit to WAIT; that tick does not trigger a decision.
- Bullet threat and attack both possible: the bullet rule wins.

## Configuration
ENEMY_AI_RANDOM_EN:
- Defined:
  - Rule 3 fires only if lfsr[1:0] ≠ 0.
  - Rule 4 is active.
- Undefined:
  - Rule 3 fires whenever the attack cooldown is 0.
  - Rule 4 always selects idle.
  - The LFSR and its sub-module are not instantiated.
  - Behaviour is fully deterministic.

## Structure
- game_pkg holds:
  - POS_WIDTH
  - ai_state_e (IDLE, WAIT, DECIDE, ACT, DEFEND)
  - ai_action_e (NONE, LEFT, RIGHT, JUMP, SQUAT, ATTACK, DEFEND)
- Sub-module ai_lfsr16 (clk, rst_n, seed parameter, 16-bit out), instantiated only under ENEMY_AI_RANDOM_EN.

## Test plan
- Reset, then i_enable=1, player_x=400, enemy_x=100, one tick → o_right=1 two clks after the tick, held 8 ticks, then 0.
- Bullet active, bullet_x=120, enemy_x=100 → o_defend=1 for 16 ticks; a repeat threat on the next decision gives a single-clk o_jump instead.
- Macro undefined, player_x=enemy_x=200, repeated ticks → o_attack pulses exactly once per 32-tick window, no other outputs.
- i_enable drops mid-DEFEND → o_defend=0 on the next clk, state IDLE; re-enable waits for a tick before any action.
- Macro defined, 1000 decisions at close range → o_left&o_right never both 1; o_jump is never wider than 1 clk; LFSR never reaches 0.
